// File: rtl/mul_err_monitor_if.sv
// Sample stream into the error monitor: one operand pair plus the approximate product under test.
interface mul_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] z;

  modport master (output in_valid, output x, output y, output z, input in_ready);
  modport slave  (input in_valid, input x, input y, input z, output in_ready);
endinterface

// File: rtl/mul_err_monitor.sv
// Streaming error-distance statistics for an 8x8 approximate multiplier: over a run of
// n samples, counts erroneous products and tracks the summed and worst-case |x*y - z|.
module mul_err_monitor #(
  parameter int N_W   = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_W-1:0]     n_samples,
  mul_err_monitor_if.slave   smp,
  output logic               busy,
  output logic               done,
  output logic [N_W-1:0]     err_count,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [15:0]        max_ed,
  output logic [7:0]         max_x,
  output logic [7:0]         max_y
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [N_W-1:0]   cnt_q, cnt_d;

  logic             in_ready;
  logic             accept;
  logic             start_ok;

  // Stage 1: captured sample
  logic             v1_q;
  logic [7:0]       x1_q, y1_q;
  logic [15:0]      z1_q;

  // Stage 2: error distance
  logic [15:0]      exact;
  logic [15:0]      ed;
  logic             v2_q;
  logic [15:0]      ed2_q;
  logic [7:0]       x2_q, y2_q;

  // Stage 3: statistics
  logic [N_W-1:0]   err_q, err_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W:0]   sum_ext;
  logic [15:0]      maxed_q, maxed_d;
  logic [7:0]       maxx_q, maxx_d;
  logic [7:0]       maxy_q, maxy_d;

  assign in_ready     = (state_q == RUN) && (cnt_q < n_q);
  assign smp.in_ready = in_ready;
  assign accept       = smp.in_valid & in_ready;
  assign start_ok     = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d     = n_samples;
          cnt_d   = '0;
          state_d = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + N_W'(1);
          if (cnt_q + N_W'(1) == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Stage 2 still holds the last sample on this edge; stage 3 absorbs it concurrently.
        if (!v1_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    exact = 16'(x1_q) * 16'(y1_q);
    ed    = (exact >= z1_q) ? (exact - z1_q) : (z1_q - exact);
  end

  always_comb begin
    err_d   = err_q;
    sum_d   = sum_q;
    maxed_d = maxed_q;
    maxx_d  = maxx_q;
    maxy_d  = maxy_q;
    sum_ext = {1'b0, sum_q} + (ACC_W+1)'(ed2_q);
    if (start_ok) begin
      err_d   = '0;
      sum_d   = '0;
      maxed_d = '0;
      maxx_d  = '0;
      maxy_d  = '0;
    end else if (v2_q) begin
      if (ed2_q != '0) err_d = err_q + N_W'(1);
      sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      // Strict compare so the earliest sample wins a tie.
      if (ed2_q > maxed_q) begin
        maxed_d = ed2_q;
        maxx_d  = x2_q;
        maxy_d  = y2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      z1_q    <= '0;
      v2_q    <= 1'b0;
      ed2_q   <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      err_q   <= '0;
      sum_q   <= '0;
      maxed_q <= '0;
      maxx_q  <= '0;
      maxy_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      v1_q    <= accept;
      if (accept) begin
        x1_q <= smp.x;
        y1_q <= smp.y;
        z1_q <= smp.z;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        ed2_q <= ed;
        x2_q  <= x1_q;
        y2_q  <= y1_q;
      end
      err_q   <= err_d;
      sum_q   <= sum_d;
      maxed_q <= maxed_d;
      maxx_q  <= maxx_d;
      maxy_q  <= maxy_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign err_count = err_q;
  assign sum_ed    = sum_q;
  assign max_ed    = maxed_q;
  assign max_x     = maxx_q;
  assign max_y     = maxy_q;

endmodule

// File: doc/mul_err_monitor.md
Name: mul_err_monitor

Overview:
Streaming error-statistics unit that sits directly downstream of the 8x8 approximate unsigned multipliers.
- Per sample, it takes the operand pair and the approximate product, recomputes the exact product, and forms error distance ED = |x*y - z|.
- Over a programmed run of N samples it accumulates error count, sum of ED and worst-case ED (with the operands that produced it).
- Used for on-chip characterisation of the approximate multipliers.

Parameters:
N_W, 16, width of sample counter, n_samples and err_count
ACC_W, 32, width of sum_ed accumulator (saturating)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a run; sampled only in IDLE or DONE
n_samples  in  N_W  samples per run, latched on accepted start
in_valid  in  1  sample present on x/y/z
in_ready  out  1  unit accepts sample this cycle
x  in  8  multiplier operand
y  in  8  multiplier operand
z  in  16  approximate product under test
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE; statistics final
err_count  out  N_W  number of samples with ED != 0
sum_ed  out  ACC_W  sum of ED, saturating
max_ed  out  16  largest ED seen
max_x  out  8  x of first sample reaching max_ed
max_y  out  8  y of first sample reaching max_ed

Behaviour:
- Reset: all outputs, stats, counters, pipeline valids = 0; state IDLE; in_ready = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start, n_samples != 0: clear stats, latch n, accepted count = 0, go RUN.
  - IDLE/DONE + start, n_samples == 0: clear stats, go DONE on the next edge.
  - RUN: in_ready = 1 while accepted count < n. Accept = in_valid & in_ready.
  - RUN -> DRAIN on the edge of the n-th accept; in_ready = 0 from the following cycle.
  - DRAIN -> DONE on the first edge where stage-1 valid = 0; the final accumulation lands on that same edge.
  - DONE: stats held, done = 1 until the next start.
- Start in RUN/DRAIN is ignored. in_ready = 0 in IDLE, DRAIN and DONE.
- Pipeline (samples are never dropped; no stall path needed):
  - S1 registers x, y, z and v1 on accept.
  - S2 computes exact = x*y (16 b, max 65025) and ED = |exact - z| (16 b unsigned, max 65535); registers ED, x, y, v2.
  - S3 on v2: err_count += (ED != 0); sum_ed = min(sum_ed + ED, 2^ACC_W - 1); if ED > max_ed (strict), load max_ed, max_x, max_y.
  - Ties keep the earliest sample.
- Latency: final accept at edge E0 -> done = 1 and stats final after E0+2. Stats for sample k are visible 2 edges after its accept.
- err_count cannot overflow: at most n <= 2^N_W - 1.
- rst mid-run: immediate return to reset state; in-flight samples are discarded.
- Back-to-back runs: start in the DONE cycle is accepted. Stats clear on that edge and done drops the next cycle.

Test Plan:
1. n=1; sample (255,255,z=65025) -> err_count=0, sum_ed=0, max_ed=0; done=1 exactly 2 cycles after the accept edge; in_ready=0 after accept.
2. n=3; samples (3,5,14), (10,10,96), (2,2,4) -> err_count=2, sum_ed=5, max_ed=4, max_x=10, max_y=10.
3. Tie: n=2; (1,1,3), (2,2,6), both ED=2 -> max_ed=2, max_x=1, max_y=1.
4. n=4 with in_valid gaps of 0-3 cycles and in_valid held high after the 4th accept -> exactly 4 accepts, a 5th sample is never taken, and stats match the model.
5. n_samples=0 start -> done=1 the next cycle, all stats 0, in_ready never high. Start while busy mid-run -> no effect on the run.
6. Reset and saturation:
   - rst after 2 of 5 accepts -> all outputs 0, IDLE; a new n=1 run completes correctly.
   - ACC_W=16 with n=2 samples of (0,0,65535) -> sum_ed=65535 (saturated), err_count=2, max_ed=65535.
